// File: rtl/spi_mem_responder_pkg.sv
// Shared constants and state encoding for the SPI memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_mem_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ    = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE   = 8'h02;
    localparam int         CMD_BITS        = 8;
    localparam int         ADDR_FIELD_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes sclk/mosi/cs_n into clk and flags sclk rising/falling edges.
// Latency: SYNC_STAGES clks from pin to synchronized level / edge strobe.
// Backpressure: none; edges are single-clk strobes.
//
// Ports: clk, rst_n (sync, active-low); sclk, mosi, cs_n raw pins;
//        sclk_rise/sclk_fall edge strobes, mosi_s and cs_n_s synchronized levels.
// SYNC_STAGES must be at least 2.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi_s,
    output logic cs_n_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;
    logic                   sclk_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            // Reset to deselected so a held-low cs_n is not mistaken for a new frame
            // until the chain has refilled.
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target serving READ(0x03)/WRITE(0x02) with 24-bit address from a byte array.
// Latency: wr_valid and each miso bit follow the physical sclk edge by SYNC_STAGES+1 clks.
// Backpressure: none; the master paces everything and sclk must be at most clk/4.
//
// Ports: clk, rst_n (sync, active-low); sclk/mosi/cs_n from the master;
//        miso/miso_oe target data and drive enable; wr_valid/wr_addr/wr_data commit
//        strobe per written byte; busy whenever the FSM is out of IDLE.
module spi_mem_responder
    import spi_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs_n,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 wr_valid,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy
);

    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_FIELD_BITS - 1);
    localparam logic [4:0] BYTE_LAST = 5'd7;

    logic sclk_rise, sclk_fall, mosi_s, cs_n_s;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_s    (mosi_s),
        .cs_n_s    (cs_n_s)
    );

    logic [7:0] mem [DEPTH];

    spi_state_t           state, state_nxt;
    logic [7:0]           shift_q, shift_nxt;
    logic [4:0]           bit_cnt, bit_cnt_nxt;
    logic [ADDR_BITS-1:0] addr_q, addr_nxt;
    logic                 is_read_q, is_read_nxt;
    logic                 miso_nxt, miso_oe_nxt;
    logic                 wr_valid_nxt;
    logic [ADDR_BITS-1:0] wr_addr_nxt;
    logic [7:0]           wr_data_nxt;
    logic                 mem_we;
    logic [7:0]           din_byte;
    logic [7:0]           rd_byte;

    // Byte as it will look once the current mosi sample is shifted in.
    assign din_byte = {shift_q[6:0], mosi_s};
    // Read straight from the array so bytes written earlier are visible at once.
    assign rd_byte  = mem[addr_q];

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        bit_cnt_nxt  = bit_cnt;
        addr_nxt     = addr_q;
        is_read_nxt  = is_read_q;
        miso_nxt     = miso;
        miso_oe_nxt  = miso_oe;
        wr_valid_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        mem_we       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!cs_n_s) begin
                    state_nxt   = ST_CMD;
                    bit_cnt_nxt = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    shift_nxt   = din_byte;
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == CMD_LAST) begin
                        bit_cnt_nxt = '0;
                        if (din_byte == SPI_CMD_READ) begin
                            state_nxt   = ST_ADDR;
                            is_read_nxt = 1'b1;
                        end else if (din_byte == SPI_CMD_WRITE) begin
                            state_nxt   = ST_ADDR;
                            is_read_nxt = 1'b0;
                        end else begin
                            state_nxt = ST_IGNORE;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise) begin
                    // Upper address bits fall off the top of the shift register.
                    addr_nxt    = ADDR_BITS'({addr_q, mosi_s});
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == ADDR_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = is_read_q ? ST_READ : ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (sclk_fall) begin
                    miso_oe_nxt = 1'b1;
                    // ~k selects bit 7-k, giving MSB-first order.
                    miso_nxt    = rd_byte[~bit_cnt[2:0]];
                    if (bit_cnt == BYTE_LAST) begin
                        bit_cnt_nxt = '0;
                        addr_nxt    = addr_q + 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (sclk_rise) begin
                    shift_nxt = din_byte;
                    if (bit_cnt == BYTE_LAST) begin
                        bit_cnt_nxt  = '0;
                        mem_we       = 1'b1;
                        wr_valid_nxt = 1'b1;
                        wr_addr_nxt  = addr_q;
                        wr_data_nxt  = din_byte;
                        addr_nxt     = addr_q + 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end
            end
            ST_IGNORE: begin
                miso_oe_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Deselect wins over everything except a byte completing in the same clk,
        // which has already been committed above.
        if (cs_n_s) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = '0;
            miso_nxt    = 1'b0;
            miso_oe_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt   <= '0;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            addr_q    <= addr_nxt;
            is_read_q <= is_read_nxt;
            miso      <= miso_nxt;
            miso_oe   <= miso_oe_nxt;
            wr_valid  <= wr_valid_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
        end
    end

    // Array contents survive reset; mem_we is only raised outside reset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[addr_q] <= din_byte;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
